// File: rtl/irq_stim_pkg.sv
// Shared types and helpers for the interrupt stimulus generator.
//   ch_state_e  : per-channel FSM state (idle, counting delay, driving a line)
//   line_width(): bits needed to select one of n interrupt lines
package irq_stim_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StAssert
    } ch_state_e;

    function automatic int unsigned line_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_stim_gen_if.sv
// Configuration / interrupt bundle between the bench (master) and the
// stimulus generator (slave).
//   addr, arm, cfg_*, irq_ack : driven by the bench
//   irq, busy                 : driven by the generator
interface irq_stim_gen_if
    import irq_stim_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IRQ_W  = 6,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned LINE_W = line_width(IRQ_W);

    logic [ADDR_W-1:0]        addr;
    logic                     arm;
    logic [NUM_CH*ADDR_W-1:0] cfg_addr;
    logic [NUM_CH*CNT_W-1:0]  cfg_delay;
    logic [NUM_CH*CNT_W-1:0]  cfg_width;
    logic [NUM_CH*CNT_W-1:0]  cfg_repeat;
    logic [NUM_CH*LINE_W-1:0] cfg_line;
    logic [NUM_CH-1:0]        cfg_level;
    logic [IRQ_W-1:0]         irq_ack;
    logic [IRQ_W-1:0]         irq;
    logic [NUM_CH-1:0]        busy;

    modport master (
        output addr, arm, cfg_addr, cfg_delay, cfg_width, cfg_repeat, cfg_line, cfg_level,
        output irq_ack,
        input  irq, busy
    );

    modport slave (
        input  addr, arm, cfg_addr, cfg_delay, cfg_width, cfg_repeat, cfg_line, cfg_level,
        input  irq_ack,
        output irq, busy
    );

endinterface

// File: rtl/irq_stim_ch.sv
// One trigger channel: IDLE -> DELAY -> ASSERT -> IDLE on an address match.
//   clk, reset       : clock, asynchronous active-low reset
//   addr_i, arm_i    : watched PC, reload of the fire budget
//   cfg_*_i          : this channel's configuration, latched when a fire starts
//   irq_ack_i        : per-line acknowledge (level mode)
//   active_o, line_o : channel is driving line_o
//   busy_o           : channel is in DELAY or ASSERT
module irq_stim_ch
    import irq_stim_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IRQ_W  = 6,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LINE_W = line_width(IRQ_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              arm_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [CNT_W-1:0]  cfg_delay_i,
    input  logic [CNT_W-1:0]  cfg_width_i,
    input  logic [CNT_W-1:0]  cfg_repeat_i,
    input  logic [LINE_W-1:0] cfg_line_i,
    input  logic              cfg_level_i,
    input  logic [IRQ_W-1:0]  irq_ack_i,
    output logic              active_o,
    output logic [LINE_W-1:0] line_o,
    output logic              busy_o
);

    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              level_q, level_d;

    logic [CNT_W-1:0]  rem_eff;
    logic [CNT_W-1:0]  width_eff;
    logic              ack_hit;
    logic              exit_assert;

    // Out-of-range lines have no acknowledge, so a level fire on one holds until reset.
    always_comb begin
        ack_hit = 1'b0;
        for (int k = 0; k < IRQ_W; k++) begin
            if (line_q == LINE_W'(k)) begin
                ack_hit = irq_ack_i[k];
            end
        end
    end

    // A same-edge arm is visible to the match decision.
    assign rem_eff     = arm_i ? cfg_repeat_i : remaining_q;
    assign width_eff   = (cfg_width_i == '0) ? CNT_W'(1) : cfg_width_i;
    assign exit_assert = level_q ? ack_hit : (cnt_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remaining_d = rem_eff;
        width_d     = width_q;
        line_d      = line_q;
        level_d     = level_q;

        unique case (state_q)
            StIdle: begin
                if (rem_eff != '0 && addr_i == cfg_addr_i) begin
                    width_d = width_eff;
                    line_d  = cfg_line_i;
                    level_d = cfg_level_i;
                    if (cfg_delay_i == '0) begin
                        state_d = StAssert;
                        cnt_d   = width_eff;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = cfg_delay_i;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StAssert;
                    cnt_d   = width_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StAssert: begin
                if (exit_assert) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    // Reload wins over the decrement when arm lands on the exit edge.
                    if (!arm_i && remaining_q != '0) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end else if (!level_q) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            remaining_q <= '0;
            width_q     <= '0;
            line_q      <= '0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            width_q     <= width_d;
            line_q      <= line_d;
            level_q     <= level_d;
        end
    end

    assign active_o = (state_q == StAssert);
    assign busy_o   = (state_q != StIdle);
    assign line_o   = line_q;

endmodule

// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator: NUM_CH address-triggered channels merged onto IRQ_W lines.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : configuration in, irq/busy out (slave side of irq_stim_gen_if)
module irq_stim_gen
    import irq_stim_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IRQ_W  = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic         clk,
    input  logic         reset,
    irq_stim_gen_if.slave bus
);

    localparam int unsigned LINE_W = line_width(IRQ_W);

    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] ch_busy;
    logic [LINE_W-1:0] ch_line [NUM_CH];
    logic [IRQ_W-1:0]  irq_or;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        irq_stim_ch #(
            .ADDR_W (ADDR_W),
            .IRQ_W  (IRQ_W),
            .CNT_W  (CNT_W),
            .LINE_W (LINE_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .addr_i       (bus.addr),
            .arm_i        (bus.arm),
            .cfg_addr_i   (bus.cfg_addr[c*ADDR_W +: ADDR_W]),
            .cfg_delay_i  (bus.cfg_delay[c*CNT_W +: CNT_W]),
            .cfg_width_i  (bus.cfg_width[c*CNT_W +: CNT_W]),
            .cfg_repeat_i (bus.cfg_repeat[c*CNT_W +: CNT_W]),
            .cfg_line_i   (bus.cfg_line[c*LINE_W +: LINE_W]),
            .cfg_level_i  (bus.cfg_level[c]),
            .irq_ack_i    (bus.irq_ack),
            .active_o     (ch_active[c]),
            .line_o       (ch_line[c]),
            .busy_o       (ch_busy[c])
        );
    end

    // Lines are a pure OR of channel state flops; lines >= IRQ_W decode to nothing.
    always_comb begin
        irq_or = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < IRQ_W; k++) begin
                if (ch_active[c] && ch_line[c] == LINE_W'(k)) begin
                    irq_or[k] = 1'b1;
                end
            end
        end
    end

    assign bus.irq  = irq_or;
    assign bus.busy = ch_busy;

endmodule

// File: tb/tb_irq_stim_gen.sv
module tb_irq_stim_gen;

    localparam int NCH  = 4;
    localparam int NIRQ = 6;
    localparam logic [31:0] IDLE_A = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    irq_stim_gen_if #(.NUM_CH(4), .ADDR_W(32), .IRQ_W(6), .CNT_W(8)) bus ();

    irq_stim_gen #(.NUM_CH(4), .ADDR_W(32), .IRQ_W(6), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each fire is a time window in edge numbers.
    int n = 0;
    bit inflt [NCH];
    int rem   [NCH];
    int s_e   [NCH];
    int w_e   [NCH];
    int ln    [NCH];
    bit lv    [NCH];
    logic [5:0] exp_irq;
    logic [3:0] exp_busy;

    int watch = 0;
    int hi_cnt = 0;
    int rises = 0;
    bit prev_hi = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            inflt[c] = 0;
            rem[c]   = 0;
        end
        exp_irq  = '0;
        exp_busy = '0;
    endtask

    task automatic model_edge();
        n++;
        for (int c = 0; c < NCH; c++) begin
            int rv;
            bit ex;
            rv = int'(bus.cfg_repeat[c*8 +: 8]);
            if (bus.arm) rem[c] = rv;
            if (inflt[c]) begin
                ex = 0;
                if (!lv[c] && n == s_e[c] + w_e[c]) ex = 1;
                if (lv[c] && n > s_e[c] && ln[c] < NIRQ && bus.irq_ack[ln[c]]) ex = 1;
                if (ex) begin
                    inflt[c] = 0;
                    if (!bus.arm && rem[c] > 0) rem[c]--;
                end
            end else if (rem[c] != 0 && bus.addr == bus.cfg_addr[c*32 +: 32]) begin
                inflt[c] = 1;
                s_e[c]   = n + int'(bus.cfg_delay[c*8 +: 8]);
                w_e[c]   = (bus.cfg_width[c*8 +: 8] == 0) ? 1 : int'(bus.cfg_width[c*8 +: 8]);
                ln[c]    = int'(bus.cfg_line[c*3 +: 3]);
                lv[c]    = bus.cfg_level[c];
            end
        end
        exp_irq  = '0;
        exp_busy = '0;
        for (int c = 0; c < NCH; c++) begin
            if (inflt[c]) begin
                exp_busy[c] = 1'b1;
                if (n >= s_e[c] && ln[c] < NIRQ) exp_irq[ln[c]] = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic [31:0] a, input bit armv);
        bus.addr = a;
        bus.arm  = armv;
        if (reset) model_edge();
        else model_clear();
        @(posedge clk);
        #1;
        chk("irq", 32'(bus.irq), 32'(exp_irq));
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        bus.arm = 1'b0;
        if (bus.irq[watch]) begin
            hi_cnt++;
            if (!prev_hi) rises++;
        end
        prev_hi = bus.irq[watch];
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(IDLE_A, 1'b0);
    endtask

    task automatic start_count(input int line);
        watch   = line;
        hi_cnt  = 0;
        rises   = 0;
        prev_hi = 0;
    endtask

    task automatic set_ch(input int c, input logic [31:0] a, input int d, input int w,
                          input int r, input int line, input bit lvl);
        bus.cfg_addr[c*32 +: 32] = a;
        bus.cfg_delay[c*8 +: 8]  = 8'(d);
        bus.cfg_width[c*8 +: 8]  = 8'(w);
        bus.cfg_repeat[c*8 +: 8] = 8'(r);
        bus.cfg_line[c*3 +: 3]   = 3'(line);
        bus.cfg_level[c]         = lvl;
    endtask

    task automatic set_defaults();
        for (int c = 0; c < NCH; c++) set_ch(c, 32'hFFFF_0000 + 32'(c), 0, 1, 0, 0, 1'b0);
    endtask

    initial begin
        bus.addr    = IDLE_A;
        bus.arm     = 1'b0;
        bus.irq_ack = '0;
        set_defaults();
        model_clear();

        // Reset state
        #1;
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        idle(3);
        reset = 1'b1;

        // Disarmed after reset: no fire without arm
        set_ch(0, 32'h3010, 0, 6, 1, 2, 1'b0);
        start_count(2);
        tick(32'h3010, 1'b0);
        idle(8);
        chk("disarmed_hi", 32'(hi_cnt), 0);

        // D=0 W=6 R=1 on line 2
        tick(IDLE_A, 1'b1);
        start_count(2);
        tick(32'h3010, 1'b0);
        idle(9);
        chk("a_hi", 32'(hi_cnt), 6);
        start_count(2);
        tick(32'h3010, 1'b0);
        idle(9);
        chk("a_second_hi", 32'(hi_cnt), 0);

        // D=3 W=2 R=2, plus a match mid-ASSERT
        set_defaults();
        set_ch(1, 32'h4000, 3, 2, 2, 1, 1'b0);
        tick(IDLE_A, 1'b1);
        start_count(1);
        tick(32'h4000, 1'b0);
        idle(3);
        tick(32'h4000, 1'b0);
        idle(5);
        tick(32'h4000, 1'b0);
        idle(9);
        chk("b_hi", 32'(hi_cnt), 4);
        chk("b_rises", 32'(rises), 2);
        start_count(1);
        tick(32'h4000, 1'b0);
        idle(9);
        chk("b_third_hi", 32'(hi_cnt), 0);

        // Level mode on line 5, ack 20 cycles after the match
        set_defaults();
        set_ch(2, 32'h5000, 0, 3, 1, 5, 1'b1);
        tick(IDLE_A, 1'b1);
        start_count(5);
        tick(32'h5000, 1'b0);
        idle(19);
        bus.irq_ack = 6'h20;
        tick(IDLE_A, 1'b0);
        bus.irq_ack = '0;
        idle(3);
        chk("lvl_hi", 32'(hi_cnt), 20);
        start_count(5);
        tick(32'h5000, 1'b0);
        idle(5);
        chk("lvl_spent_hi", 32'(hi_cnt), 0);

        // Two channels merged onto line 3
        set_defaults();
        set_ch(0, 32'h6000, 0, 4, 1, 3, 1'b0);
        set_ch(1, 32'h6008, 0, 4, 1, 3, 1'b0);
        tick(IDLE_A, 1'b1);
        start_count(3);
        tick(32'h6000, 1'b0);
        idle(1);
        tick(32'h6008, 1'b0);
        chk("merge_busy", 32'(bus.busy), 32'h3);
        idle(6);
        chk("merge_hi", 32'(hi_cnt), 6);
        chk("merge_rises", 32'(rises), 1);

        // Asynchronous reset mid-ASSERT
        set_defaults();
        set_ch(0, 32'h7000, 0, 8, 1, 0, 1'b0);
        tick(IDLE_A, 1'b1);
        tick(32'h7000, 1'b0);
        idle(2);
        chk("pre_rst_irq", 32'(bus.irq), 32'h1);
        reset = 1'b0;
        #1;
        chk("async_rst_irq", 32'(bus.irq), 32'h0);
        chk("async_rst_busy", 32'(bus.busy), 32'h0);
        model_clear();
        idle(2);
        reset = 1'b1;
        start_count(0);
        tick(32'h7000, 1'b0);
        idle(9);
        chk("post_rst_hi", 32'(hi_cnt), 0);

        // W=0 R=0, then R=1
        set_defaults();
        set_ch(2, 32'h8000, 0, 0, 0, 4, 1'b0);
        tick(IDLE_A, 1'b1);
        start_count(4);
        tick(32'h8000, 1'b0);
        idle(3);
        chk("r0_hi", 32'(hi_cnt), 0);
        set_ch(2, 32'h8000, 0, 0, 1, 4, 1'b0);
        tick(IDLE_A, 1'b1);
        start_count(4);
        tick(32'h8000, 1'b0);
        idle(3);
        chk("w0_hi", 32'(hi_cnt), 1);

        // Random segments against the window model
        for (int seg = 0; seg < 4; seg++) begin
            reset = 1'b0;
            idle(1);
            reset = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                set_ch(c, 32'h100 + 32'(4 * $urandom_range(0, 3)), $urandom_range(0, 4),
                       $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 7),
                       1'($urandom_range(0, 1)));
            end
            tick(IDLE_A, 1'b1);
            for (int i = 0; i < 120; i++) begin
                int r;
                int c;
                r = $urandom_range(0, 5);
                bus.irq_ack = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
                if (i % 30 == 29) begin
                    c = $urandom_range(0, NCH - 1);
                    set_ch(c, 32'h100 + 32'(4 * $urandom_range(0, 3)), $urandom_range(0, 4),
                           $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 7),
                           1'($urandom_range(0, 1)));
                end
                tick((r < 4) ? 32'h100 + 32'(4 * r) : IDLE_A, $urandom_range(0, 15) == 0);
            end
            bus.irq_ack = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
